// File: rtl/leaf_out_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : leaf_out_packetizer_if
// Description : Bundles the user-side payload stream and the BFT-side packet
//               ports of the leaf output packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
interface leaf_out_packetizer_if #(
  parameter int PACKET_BITS  = 49,
  parameter int PAYLOAD_BITS = 32
);
  // Control traffic arriving from the BFT (config / freespace update)
  logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
  // User kernel payload stream
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  // Packets leaving toward the BFT output mux
  logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
  logic                    ready_bft2interface;

  // Packetizer side
  modport slave (
    input  din_leaf_bft2interface,
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user,
    output dout_leaf_interface2bft,
    input  ready_bft2interface
  );

  // Environment side (user kernel + BFT)
  modport master (
    output din_leaf_bft2interface,
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user,
    input  dout_leaf_interface2bft,
    output ready_bft2interface
  );
endinterface
`default_nettype wire

// File: rtl/leaf_out_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : leaf_out_packetizer
// Description : Wraps a 32-bit user output stream into BFT packets addressed
//               to a configured (leaf, port), tracking the receiver BRAM write
//               address and credit-based flow control refilled by freespace
//               update packets.
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  wire logic            clk,
  input  wire logic            reset,
  leaf_out_packetizer_if.slave bus,
  output logic                 configured,
  output logic                 credit_overflow
);

  // Packet field positions: [valid | leaf | port | addr | payload]
  localparam int ADDR_LSB  = PAYLOAD_BITS;
  localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT = PACKET_BITS - 1;

  // Credit counter must hold the full receiver depth, hence one extra bit
  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_BITS    = 32;

  localparam logic [CREDIT_BITS-1:0]   CREDIT_MAX   = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
  localparam logic [SUM_BITS-1:0]      CREDIT_MAX_W = {{(SUM_BITS-CREDIT_BITS){1'b0}}, CREDIT_MAX};
  localparam logic [SUM_BITS-1:0]      FSU_INC      = FREESPACE_UPDATE_SIZE;
  localparam logic [NUM_ADDR_BITS-1:0] ADDR_ONE     = {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_CONFIG = 3'b001;
  localparam logic [2:0] OP_FSU    = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state;
  logic [NUM_LEAF_BITS-1:0]  dest_leaf;
  logic [NUM_PORT_BITS-1:0]  dest_port;
  logic [NUM_ADDR_BITS-1:0]  wr_addr;
  logic [CREDIT_BITS-1:0]    credit;
  logic [PACKET_BITS-1:0]    out_pkt;

  logic                      out_valid;
  logic                      is_ctrl;
  logic [2:0]                opcode;
  logic                      cfg_hit;
  logic                      fsu_hit;
  logic                      xfer;
  logic [SUM_BITS-1:0]       credit_sum;
  logic                      credit_sat;
  logic [PACKET_BITS-1:0]    new_pkt;

  // The held packet is valid exactly when its valid bit is set; an empty
  // register is all-zero, so no separate flag is needed.
  assign out_valid = out_pkt[VALID_BIT];

  // Decode incoming control traffic and compute next-credit arithmetic
  always_comb begin
    is_ctrl = bus.din_leaf_bft2interface[VALID_BIT]
            & (bus.din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0);
    opcode  = bus.din_leaf_bft2interface[PAYLOAD_BITS-1 -: 3];
    // A config naming port 0 would target the control port itself; drop it
    cfg_hit = is_ctrl && (opcode == OP_CONFIG)
            && (bus.din_leaf_bft2interface[0 +: NUM_PORT_BITS] != '0);
    fsu_hit = is_ctrl && (opcode == OP_FSU);

    xfer = bus.vld_user2interface & bus.ack_interface2user;

    // Credit is nonzero whenever a transfer happens, so this never underflows
    credit_sum = {{(SUM_BITS-CREDIT_BITS){1'b0}}, credit}
               - {{(SUM_BITS-1){1'b0}}, xfer}
               + (fsu_hit ? FSU_INC : '0);
    credit_sat = (credit_sum > CREDIT_MAX_W);

    new_pkt = {1'b1, dest_leaf, dest_port, wr_addr, bus.din_leaf_user2interface};
  end

  // Accept user data only when configured, the receiver has room, and the
  // output register is empty or draining this cycle
  assign bus.ack_interface2user = configured & (credit != '0)
                                & (~out_valid | bus.ready_bft2interface);

  assign bus.dout_leaf_interface2bft = out_pkt;

  // Destination FSM, address/credit bookkeeping and the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      configured      <= 1'b0;
      dest_leaf       <= '0;
      dest_port       <= '0;
      wr_addr         <= '0;
      credit          <= CREDIT_MAX;
      credit_overflow <= 1'b0;
      out_pkt         <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cfg_hit) state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase

      // A transfer in the same cycle as a config still uses the old
      // destination and address, captured here via new_pkt.
      if (xfer) begin
        out_pkt <= new_pkt;
      end else if (bus.ready_bft2interface) begin
        out_pkt <= '0;
      end

      if (cfg_hit) begin
        configured <= 1'b1;
        dest_leaf  <= bus.din_leaf_bft2interface[NUM_PORT_BITS +: NUM_LEAF_BITS];
        dest_port  <= bus.din_leaf_bft2interface[0 +: NUM_PORT_BITS];
        wr_addr    <= '0;
        credit     <= CREDIT_MAX;
      end else begin
        if (xfer) wr_addr <= wr_addr + ADDR_ONE;
        if (credit_sat) begin
          credit          <= CREDIT_MAX;
          credit_overflow <= 1'b1;
        end else begin
          credit <= credit_sum[CREDIT_BITS-1:0];
        end
      end
    end
  end

  // Field offsets kept for readability of the packet layout
  logic unused_fields;
  assign unused_fields = ^{LEAF_LSB[0], ADDR_LSB[0]};

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_out_packetizer
// Description : Directed + randomized bench for leaf_out_packetizer against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_out_packetizer;

  logic clk;
  logic reset;
  logic configured;
  logic credit_overflow;

  int checks   = 0;
  int failures = 0;

  leaf_out_packetizer_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32)) bus ();

  leaf_out_packetizer dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .configured      (configured),
    .credit_overflow (credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_cfg;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  int          m_addr;
  int          m_credit;
  bit          m_ovf;
  logic [48:0] m_dout;

  function automatic logic [48:0] cfg_pkt(input logic [4:0] leaf, input logic [3:0] port);
    return {1'b1, 5'd0, 4'd0, 7'd0, 3'b001, 20'd0, leaf, port};
  endfunction

  function automatic logic [48:0] fsu_pkt();
    return {1'b1, 5'd0, 4'd0, 7'd0, 3'b010, 29'd0};
  endfunction

  task automatic model_reset();
    m_cfg = 0; m_leaf = '0; m_port = '0; m_addr = 0;
    m_credit = 128; m_ovf = 0; m_dout = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input bit rs, input bit v, input logic [31:0] p,
                      input bit rdy, input logic [48:0] bft, output bit acc);
    bit exp_ack;
    bit ctrl;
    bit is_cfg;
    bit is_fsu;
    int c;
    @(negedge clk);
    reset = rs;
    bus.vld_user2interface      = v;
    bus.din_leaf_user2interface = p;
    bus.ready_bft2interface     = rdy;
    bus.din_leaf_bft2interface  = bft;
    #1;
    exp_ack = m_cfg && (m_credit != 0) && (!m_dout[48] || rdy);
    check("ack", {63'd0, bus.ack_interface2user}, {63'd0, exp_ack});
    check("dout", {15'd0, bus.dout_leaf_interface2bft}, {15'd0, m_dout});
    check("configured", {63'd0, configured}, {63'd0, m_cfg});
    check("overflow", {63'd0, credit_overflow}, {63'd0, m_ovf});
    acc = v && exp_ack && !rs;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      ctrl   = bft[48] && (bft[42:39] == 4'd0);
      is_cfg = ctrl && (bft[31:29] == 3'b001) && (bft[3:0] != 4'd0);
      is_fsu = ctrl && (bft[31:29] == 3'b010);
      if (acc) begin
        m_dout = {1'b1, m_leaf, m_port, 7'(m_addr), p};
        m_addr = (m_addr + 1) % 128;
      end else if (rdy) begin
        m_dout = '0;
      end
      if (is_cfg) begin
        m_cfg = 1; m_leaf = bft[8:4]; m_port = bft[3:0];
        m_addr = 0; m_credit = 128;
      end else begin
        c = m_credit - (acc ? 1 : 0) + (is_fsu ? 64 : 0);
        if (c > 128) begin
          c = 128;
          m_ovf = 1;
        end
        m_credit = c;
      end
    end
  endtask

  initial begin
    bit          acc;
    int          n;
    logic [48:0] held;
    logic [48:0] b;
    logic [31:0] r32;
    int          sel;

    reset = 1'b1;
    bus.vld_user2interface      = 1'b0;
    bus.din_leaf_user2interface = '0;
    bus.ready_bft2interface     = 1'b0;
    bus.din_leaf_bft2interface  = '0;
    model_reset();

    // Reset
    repeat (3) step(1, 0, 32'd0, 1, '0, acc);

    // Unconfigured: no acceptance, no output
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, $urandom, 1, '0, acc);
      if (acc) n++;
    end
    check("idle_accepts", 64'(n), 64'd0);

    // Config leaf 5 port 3, then first packets
    step(0, 0, 32'd0, 1, cfg_pkt(5'd5, 4'd3), acc);
    step(0, 1, 32'hDEADBEEF, 1, '0, acc);
    check("first_acc", {63'd0, acc}, 64'd1);
    #1;
    check("first_pkt", {15'd0, bus.dout_leaf_interface2bft},
          {15'd0, 1'b1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF});
    step(0, 1, 32'h12345678, 1, '0, acc);
    #1;
    check("second_pkt", {15'd0, bus.dout_leaf_interface2bft},
          {15'd0, 1'b1, 5'd5, 4'd3, 7'd1, 32'h12345678});

    // Credit exhaustion: 130 offered, 128 accepted
    step(0, 0, 32'd0, 1, cfg_pkt(5'd5, 4'd3), acc);
    n = 0;
    for (int i = 0; i < 130; i++) begin
      step(0, 1, $urandom, 1, '0, acc);
      if (acc) n++;
    end
    check("credit_128", 64'(n), 64'd128);
    step(0, 1, $urandom, 1, fsu_pkt(), acc);
    check("fsu_cycle_acc", {63'd0, acc}, 64'd0);
    step(0, 1, $urandom, 1, '0, acc);
    check("fsu_next_acc", {63'd0, acc}, 64'd1);
    n = 1;
    for (int i = 0; i < 69; i++) begin
      step(0, 1, $urandom, 1, '0, acc);
      if (acc) n++;
    end
    check("credit_64", 64'(n), 64'd64);

    // Backpressure hold then back-to-back release
    step(0, 0, 32'd0, 1, fsu_pkt(), acc);
    step(0, 1, 32'hA5A5_0001, 0, '0, acc);
    check("hold_load", {63'd0, acc}, 64'd1);
    held = m_dout;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, $urandom, 0, '0, acc);
      if (acc) n++;
      check("hold_stable", {15'd0, bus.dout_leaf_interface2bft}, {15'd0, held});
    end
    check("hold_accepts", 64'(n), 64'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, $urandom, 1, '0, acc);
      if (acc) n++;
    end
    check("b2b_accepts", 64'(n), 64'd5);

    // Saturation at full credit sets the sticky overflow flag
    step(0, 0, 32'd0, 1, cfg_pkt(5'd2, 4'd6), acc);
    step(0, 0, 32'd0, 1, fsu_pkt(), acc);
    #1;
    check("overflow_set", {63'd0, credit_overflow}, 64'd1);
    n = 0;
    for (int i = 0; i < 118; i++) begin
      step(0, 1, $urandom, 1, '0, acc);
      if (acc) n++;
    end
    check("drain_118", 64'(n), 64'd118);
    // Transfer plus update at credit 10 leaves 73
    step(0, 1, $urandom, 1, fsu_pkt(), acc);
    check("xfer_fsu_acc", {63'd0, acc}, 64'd1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 1, $urandom, 1, '0, acc);
      if (acc) n++;
    end
    check("credit_73", 64'(n), 64'd73);

    // Reset mid-stream
    step(0, 0, 32'd0, 1, cfg_pkt(5'd3, 4'd1), acc);
    repeat (3) step(0, 1, $urandom, 1, '0, acc);
    step(1, 1, $urandom, 1, '0, acc);
    #1;
    check("rst_configured", {63'd0, configured}, 64'd0);
    check("rst_dout", {15'd0, bus.dout_leaf_interface2bft}, 64'd0);
    check("rst_ack", {63'd0, bus.ack_interface2user}, 64'd0);
    step(0, 0, 32'd0, 1, cfg_pkt(5'd9, 4'd7), acc);
    step(0, 1, 32'hCAFEF00D, 1, '0, acc);
    #1;
    check("reconfig_pkt", {15'd0, bus.dout_leaf_interface2bft},
          {15'd0, 1'b1, 5'd9, 4'd7, 7'd0, 32'hCAFEF00D});

    // Randomized traffic with mixed control packets
    for (int i = 0; i < 1500; i++) begin
      r32 = $urandom;
      sel = $urandom_range(0, 29);
      case (sel)
        0:       b = cfg_pkt(r32[4:0], r32[8:5]);
        1, 2:    b = fsu_pkt();
        3:       b = {1'b1, r32[4:0], 4'd0, r32[11:5], 3'($urandom_range(3, 7)), 29'($urandom)};
        4:       b = {1'b1, r32[4:0], 4'($urandom_range(1, 15)), r32[11:5], 3'b001, 29'($urandom)};
        5:       b = {1'b0, r32[4:0], 4'd0, r32[11:5], 3'b010, 29'd0};
        default: b = '0;
      endcase
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 3) != 0), b, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
